// File: rtl/seg7_scan_mux_4dig_if.sv
// Bundle between a 4-digit 7-segment scanner and its host/display side:
// value/load/mask in, load acknowledge, current nibble (w = MSB) and anodes out.
interface seg7_scan_mux_4dig_if;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  digit_mask;
  logic        load_ack;
  logic        w;
  logic        x;
  logic        y;
  logic        z;
  logic [3:0]  an;

  modport master (
    output value_in, load, digit_mask,
    input  load_ack, w, x, y, z, an
  );

  modport slave (
    input  value_in, load, digit_mask,
    output load_ack, w, x, y, z, an
  );
endinterface

// File: rtl/seg7_scan_mux_4dig.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display; values adopted only at frame
// boundaries. Optional leading-zero blanking when SEG7_LEAD_ZERO_BLANK_EN is defined.
module seg7_scan_mux_4dig #(
  parameter int PRESCALE_DIV     = 100000,
  parameter int BLANK_GUARD      = 16,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_scan_mux_4dig_if.slave  bus
);

  localparam int CNT_W = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam int GRD_W = (BLANK_GUARD > 0) ? $clog2(BLANK_GUARD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE_DIV - 1);
  localparam logic [GRD_W-1:0] GRD_INIT = GRD_W'(BLANK_GUARD);
  localparam logic [3:0]       AN_OFF   = (ANODE_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd0:    nibble_of = v[3:0];
      2'd1:    nibble_of = v[7:4];
      2'd2:    nibble_of = v[11:8];
      default: nibble_of = v[15:12];
    endcase
  endfunction

  function automatic logic [3:0] anode_drive(input logic [3:0] on);
    anode_drive = (ANODE_ACTIVE_LOW != 0) ? ~on : on;
  endfunction

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  // Digits above the highest nonzero nibble stay dark; digit 0 is always shown.
  function automatic logic [3:0] lead_zero_en(input logic [15:0] v);
    lead_zero_en = {|v[15:12], |v[15:8], |v[15:4], 1'b1};
  endfunction
`endif

  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [1:0]       idx_q, idx_nx;
  logic [GRD_W-1:0] guard_q, guard_nx;
  logic [15:0]      shadow_q, shadow_nx;
  logic [15:0]      disp_q, disp_nx;
  logic             pending_q, pending_nx;
  logic             ack_q, ack_nx;
  logic [3:0]       nib_q, nib_nx;
  logic [3:0]       an_q, an_nx;
  logic             tick;
  logic             frame_end;
  logic             adopt;
  logic [3:0]       en_nx;
  logic [3:0]       on_nx;

  always_comb begin
    tick       = (cnt_q == CNT_LAST);
    frame_end  = tick && (idx_q == 2'd3);
    adopt      = frame_end && pending_q;

    cnt_nx     = tick ? '0 : cnt_q + 1'b1;
    idx_nx     = tick ? idx_q + 2'd1 : idx_q;
    guard_nx   = guard_q;
    if (tick)
      guard_nx = GRD_INIT;
    else if (guard_q != '0)
      guard_nx = guard_q - 1'b1;

    // Shadow sees the new load while disp takes the value held before this cycle.
    disp_nx    = adopt ? shadow_q : disp_q;
    shadow_nx  = bus.load ? bus.value_in : shadow_q;
    pending_nx = pending_q;
    if (bus.load)
      pending_nx = 1'b1;
    else if (adopt)
      pending_nx = 1'b0;
    ack_nx     = adopt;

    // The nibble switches on the slot edge, while the guard keeps the anode dark.
    nib_nx     = tick ? nibble_of(disp_nx, idx_nx) : nib_q;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    en_nx      = bus.digit_mask & lead_zero_en(disp_nx);
`else
    en_nx      = bus.digit_mask;
`endif
    on_nx      = (guard_nx == '0) ? (en_nx & (4'b0001 << idx_nx)) : 4'b0000;
    an_nx      = anode_drive(on_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      guard_q   <= GRD_INIT;
      shadow_q  <= 16'h0000;
      disp_q    <= 16'h0000;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      nib_q     <= 4'h0;
      an_q      <= AN_OFF;
    end else begin
      cnt_q     <= cnt_nx;
      idx_q     <= idx_nx;
      guard_q   <= guard_nx;
      shadow_q  <= shadow_nx;
      disp_q    <= disp_nx;
      pending_q <= pending_nx;
      ack_q     <= ack_nx;
      nib_q     <= nib_nx;
      an_q      <= an_nx;
    end
  end

  assign bus.load_ack = ack_q;
  assign bus.w        = nib_q[3];
  assign bus.x        = nib_q[2];
  assign bus.y        = nib_q[1];
  assign bus.z        = nib_q[0];
  assign bus.an       = an_q;

endmodule

// File: tb/tb_seg7_scan_mux_4dig.sv
// Directed bench for seg7_scan_mux_4dig with PRESCALE_DIV=4, BLANK_GUARD=1, active-low anodes.
module tb_seg7_scan_mux_4dig;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_mux_4dig_if bus();

  seg7_scan_mux_4dig #(
    .PRESCALE_DIV(4),
    .BLANK_GUARD(1),
    .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int ecnt = 0;
  int s, j, acks;
  logic [3:0] wxyz, exp_an, oh, en;
  logic [3:0] nib [4];

  assign wxyz = {bus.w, bus.x, bus.y, bus.z};

  task automatic step;
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic restart;
    bus.load = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ecnt = 0;
  endtask

  task automatic test_reset;
    restart();
    step(); step();
    bus.value_in = 16'h9999; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while (ecnt < 9) step();
    vectors++;
    if (bus.an !== 4'b1011) begin miscompares++; $display("FAIL pre_reset_an: got %b expected 1011", bus.an); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.an !== 4'b1111) begin miscompares++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
    vectors++;
    if (wxyz !== 4'h0) begin miscompares++; $display("FAIL reset_wxyz: got %h expected 0", wxyz); end
    vectors++;
    if (bus.load_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", bus.load_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    ecnt = 0;
    step(); step();
    vectors++;
    if (bus.an !== 4'b1110) begin miscompares++; $display("FAIL release_an: got %b expected 1110", bus.an); end
    acks = 0;
    repeat (40) begin
      step();
      if (bus.load_ack === 1'b1) acks++;
    end
    vectors++;
    if (acks !== 0) begin miscompares++; $display("FAIL discarded_ack: got %0d acks expected 0", acks); end
    vectors++;
    if (wxyz !== 4'h0) begin miscompares++; $display("FAIL discarded_wxyz: got %h expected 0", wxyz); end
  endtask

  task automatic test_mask_change;
    restart();
    step(); step();
    vectors++;
    if (bus.an !== 4'b1110) begin miscompares++; $display("FAIL mask_on: got %b expected 1110", bus.an); end
    bus.digit_mask = 4'h0;
    step();
    vectors++;
    if (bus.an !== 4'b1111) begin miscompares++; $display("FAIL mask_off: got %b expected 1111", bus.an); end
    bus.digit_mask = 4'hF;
    step(); step();
    vectors++;
    if (bus.an !== 4'b1101) begin miscompares++; $display("FAIL mask_restore: got %b expected 1101", bus.an); end
  endtask

  task automatic test_load_scan;
    restart();
    nib[0] = 4'h7; nib[1] = 4'hF; nib[2] = 4'h3; nib[3] = 4'hA;
    bus.value_in = 16'hA3F7; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while (ecnt < 16) begin
      step();
      vectors++;
      if (ecnt < 16 && bus.load_ack !== 1'b0) begin miscompares++; $display("FAIL early_ack e%0d: got %b expected 0", ecnt, bus.load_ack); end
      if (ecnt == 16 && bus.load_ack !== 1'b1) begin miscompares++; $display("FAIL boundary_ack: got %b expected 1", bus.load_ack); end
    end
    for (int e = 16; e < 32; e++) begin
      if (e > 16) step();
      s = (e / 4) % 4; j = e % 4;
      oh = 4'b0001 << s;
      exp_an = (j == 0) ? 4'hF : ~oh;
      vectors++;
      if (bus.an !== exp_an) begin miscompares++; $display("FAIL scan_an e%0d: got %b expected %b", e, bus.an, exp_an); end
      vectors++;
      if (wxyz !== nib[s]) begin miscompares++; $display("FAIL scan_wxyz e%0d: got %h expected %h", e, wxyz, nib[s]); end
      if (e > 16) begin
        vectors++;
        if (bus.load_ack !== 1'b0) begin miscompares++; $display("FAIL extra_ack e%0d: got %b expected 0", e, bus.load_ack); end
      end
    end
  endtask

  task automatic test_double_load;
    restart();
    step();
    bus.value_in = 16'h1111; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step(); step();
    bus.value_in = 16'h2222; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    acks = 0;
    while (ecnt < 40) begin
      step();
      if (bus.load_ack === 1'b1) acks++;
      if (ecnt == 16) begin
        vectors++;
        if (bus.load_ack !== 1'b1) begin miscompares++; $display("FAIL dbl_ack_time: got %b expected 1", bus.load_ack); end
      end
      if (ecnt >= 16 && ecnt < 32) begin
        vectors++;
        if (wxyz !== 4'h2) begin miscompares++; $display("FAIL dbl_wxyz e%0d: got %h expected 2", ecnt, wxyz); end
      end
    end
    vectors++;
    if (acks !== 1) begin miscompares++; $display("FAIL dbl_ack_count: got %0d expected 1", acks); end
  endtask

  task automatic test_back_to_back;
    restart();
    step(); step();
    bus.value_in = 16'h4444; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while (ecnt < 15) step();
    bus.value_in = 16'h5555; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    vectors++;
    if (bus.load_ack !== 1'b1) begin miscompares++; $display("FAIL b2b_ack1: got %b expected 1", bus.load_ack); end
    vectors++;
    if (wxyz !== 4'h4) begin miscompares++; $display("FAIL b2b_wxyz1: got %h expected 4", wxyz); end
    while (ecnt < 31) begin
      step();
      vectors++;
      if (bus.load_ack !== 1'b0 || wxyz !== 4'h4) begin
        miscompares++;
        $display("FAIL b2b_hold e%0d: got ack=%b wxyz=%h expected ack=0 wxyz=4", ecnt, bus.load_ack, wxyz);
      end
    end
    step();
    vectors++;
    if (bus.load_ack !== 1'b1) begin miscompares++; $display("FAIL b2b_ack2: got %b expected 1", bus.load_ack); end
    vectors++;
    if (wxyz !== 4'h5) begin miscompares++; $display("FAIL b2b_wxyz2: got %h expected 5", wxyz); end
    step();
    vectors++;
    if (bus.load_ack !== 1'b0) begin miscompares++; $display("FAIL b2b_ack_pulse: got %b expected 0", bus.load_ack); end
  endtask

  task automatic test_digit_mask;
    restart();
    nib[0] = 4'h4; nib[1] = 4'h3; nib[2] = 4'h2; nib[3] = 4'h1;
    bus.digit_mask = 4'b0101;
    bus.value_in = 16'h1234; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while (ecnt < 16) step();
    for (int e = 16; e < 32; e++) begin
      if (e > 16) step();
      s = (e / 4) % 4; j = e % 4;
      oh = 4'b0001 << s;
      exp_an = (j == 0 || s == 1 || s == 3) ? 4'hF : ~oh;
      vectors++;
      if (bus.an !== exp_an) begin miscompares++; $display("FAIL mask_an e%0d: got %b expected %b", e, bus.an, exp_an); end
      vectors++;
      if (wxyz !== nib[s]) begin miscompares++; $display("FAIL mask_wxyz e%0d: got %h expected %h", e, wxyz, nib[s]); end
    end
    bus.digit_mask = 4'hF;
  endtask

  task automatic test_lead_zero;
    restart();
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    en = 4'b0001;
`else
    en = 4'b1111;
`endif
    bus.value_in = 16'h0050; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int e = 1; e < 16; e++) begin
      if (e > 1) step();
      s = (e / 4) % 4; j = e % 4;
      oh = 4'b0001 << s;
      exp_an = (j == 0 || !en[s]) ? 4'hF : ~oh;
      vectors++;
      if (bus.an !== exp_an || wxyz !== 4'h0) begin
        miscompares++;
        $display("FAIL lz_zero e%0d: got an=%b wxyz=%h expected an=%b wxyz=0", e, bus.an, wxyz, exp_an);
      end
    end
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    en = 4'b0011;
`else
    en = 4'b1111;
`endif
    nib[0] = 4'h0; nib[1] = 4'h5; nib[2] = 4'h0; nib[3] = 4'h0;
    for (int e = 16; e < 32; e++) begin
      step();
      s = (e / 4) % 4; j = e % 4;
      oh = 4'b0001 << s;
      exp_an = (j == 0 || !en[s]) ? 4'hF : ~oh;
      vectors++;
      if (bus.an !== exp_an || wxyz !== nib[s]) begin
        miscompares++;
        $display("FAIL lz_0050 e%0d: got an=%b wxyz=%h expected an=%b wxyz=%h", e, bus.an, wxyz, exp_an, nib[s]);
      end
    end
  endtask

  initial begin
    bus.value_in = 16'h0000;
    bus.load = 1'b0;
    bus.digit_mask = 4'hF;
    test_reset();
    test_mask_change();
    test_load_scan();
    test_double_load();
    test_back_to_back();
    test_digit_mask();
    test_lead_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
